// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for muldiv_unit
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request and regfile write-port bundle for muldiv_unit
interface muldiv_if #(
  parameter int XLEN = muldiv_pkg::XLEN
);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] wd3;
  logic [4:0]      wa3;
  logic            we3;

  modport master (
    output start, funct3, a, b, rd,
    input  busy, done, wd3, wa3, we3
  );

  modport slave (
    input  start, funct3, a, b, rd,
    output busy, done, wd3, wa3, we3
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - fixed-latency radix-2 multiply/divide unit driving a regfile write port
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  state_e            state;
  state_e            state_nxt;
  op_e               op_q;
  op_e               op_in;
  logic              neg_q;
  logic              neg_in;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [CW-1:0]     cnt;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   wd3_q;
  logic [4:0]        wa3_q;
  logic              accept;
  logic              last_iter;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result;

  assign op_in     = op_e'(bus.funct3);
  assign accept    = (state == ST_IDLE) && bus.start;
  assign last_iter = (state == ST_RUN) && (cnt == CW'(XLEN - 1));
  assign a_neg     = bus.a[XLEN-1];
  assign b_neg     = bus.b[XLEN-1];
  assign mag_a     = (a_signed(op_in) && a_neg) ? -bus.a : bus.a;
  assign mag_b     = (b_signed(op_in) && b_neg) ? -bus.b : bus.b;

  // Divide by zero keeps the all-ones quotient unsigned so it is not negated.
  always_comb begin
    case (op_in)
      OP_MULH:   neg_in = a_neg ^ b_neg;
      OP_MULHSU: neg_in = a_neg;
      OP_DIV:    neg_in = (a_neg ^ b_neg) && (bus.b != '0);
      OP_REM:    neg_in = a_neg;
      default:   neg_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CW'(XLEN - 1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != ST_IDLE);
    bus.done = (state == ST_DONE);
    bus.we3  = (state == ST_DONE) && (wa3_q != 5'd0);
    bus.wd3  = wd3_q;
    bus.wa3  = wa3_q;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opb};
    if (is_div(op_q)) begin
      if (diff[XLEN]) begin
        acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quo;
      default:                     result = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      rd_q  <= '0;
      wd3_q <= '0;
      wa3_q <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      neg_q <= neg_in;
      opb   <= mag_b;
      acc   <= {{XLEN{1'b0}}, mag_a};
      cnt   <= '0;
      rd_q  <= bus.rd;
    end else if (state == ST_RUN) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        wd3_q <= result;
        wa3_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_count = 0;
  int wr_count = 0;
  logic [31:0] rf [32];

  // Regfile model: stores every write, including any to x0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_count <= done_count + 1;
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.we3) begin
      rf[bus.wa3] <= bus.wd3;
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p = '0;
    case (f)
      3'b000: begin p = ua * ub; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] wa, output logic we, output int lat,
                        output logic [31:0] res_after, output logic done_after, output int done_cyc);
    int n;
    n = 0;
    lat = -1;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.a = a;
    bus.b = b;
    bus.rd = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    bus.rd = 5'($urandom);
    for (int k = 1; k <= XLEN + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    res = bus.wd3;
    wa = bus.wa3;
    we = bus.we3;
    done_cyc = cyc;
    @(posedge clk);
    #1;
    res_after = bus.wd3;
    done_after = bus.done;
  endtask

  task automatic test_reset();
    logic [31:0] res, res_after;
    logic [4:0] wa;
    logic we, done_after;
    int lat, dcyc;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'd1;
    bus.rd = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.we3 !== 1'b0) $display("FAIL reset_we3 got %b want 0", bus.we3); else n_pass++;
    n_checks++; if (bus.wd3 !== 32'd0) $display("FAIL reset_wd3 got %h want 0", bus.wd3); else n_pass++;
    n_checks++; if (bus.wa3 !== 5'd0) $display("FAIL reset_wa3 got %0d want 0", bus.wa3); else n_pass++;
    #1;
    reset = 1'b0;
    run_op(3'b000, 32'd7, 32'd6, 5'd5, res, wa, we, lat, res_after, done_after, dcyc);
    n_checks++; if (lat !== XLEN) $display("FAIL mul7x6_latency got %0d want %0d", lat, XLEN); else n_pass++;
    n_checks++; if (res !== 32'h0000_002A) $display("FAIL mul7x6_wd3 got %h want 0000002a", res); else n_pass++;
    n_checks++; if (wa !== 5'd5) $display("FAIL mul7x6_wa3 got %0d want 5", wa); else n_pass++;
    n_checks++; if (we !== 1'b1) $display("FAIL mul7x6_we3 got %b want 1", we); else n_pass++;
    n_checks++; if (done_after !== 1'b0) $display("FAIL mul7x6_done_pulse got %b want 0", done_after); else n_pass++;
    n_checks++; if (res_after !== 32'h0000_002A) $display("FAIL mul7x6_wd3_hold got %h want 0000002a", res_after); else n_pass++;
    n_checks++; if (rf[5] !== 32'h0000_002A) $display("FAIL mul7x6_rf5 got %h want 0000002a", rf[5]); else n_pass++;
  endtask

  task automatic test_directed();
    logic [2:0] tf [9];
    logic [31:0] ta [9];
    logic [31:0] tbv [9];
    logic [31:0] te [9];
    logic [31:0] res, res_after;
    logic [4:0] wa;
    logic we, done_after;
    int lat, dcyc;
    tf[0] = 3'b011; ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'hFFFF_FFFF; te[0] = 32'hFFFF_FFFE;
    tf[1] = 3'b001; ta[1] = 32'hFFFF_FFFF; tbv[1] = 32'hFFFF_FFFF; te[1] = 32'h0000_0000;
    tf[2] = 3'b010; ta[2] = 32'hFFFF_FFFF; tbv[2] = 32'd2;         te[2] = 32'hFFFF_FFFF;
    tf[3] = 3'b101; ta[3] = 32'd100;       tbv[3] = 32'd0;         te[3] = 32'hFFFF_FFFF;
    tf[4] = 3'b111; ta[4] = 32'd100;       tbv[4] = 32'd0;         te[4] = 32'd100;
    tf[5] = 3'b100; ta[5] = 32'h8000_0000; tbv[5] = 32'hFFFF_FFFF; te[5] = 32'h8000_0000;
    tf[6] = 3'b110; ta[6] = 32'h8000_0000; tbv[6] = 32'hFFFF_FFFF; te[6] = 32'h0000_0000;
    tf[7] = 3'b100; ta[7] = 32'hFFFF_FFF9; tbv[7] = 32'd2;         te[7] = 32'hFFFF_FFFD;
    tf[8] = 3'b110; ta[8] = 32'hFFFF_FFF9; tbv[8] = 32'd2;         te[8] = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      run_op(tf[i], ta[i], tbv[i], 5'(i + 1), res, wa, we, lat, res_after, done_after, dcyc);
      n_checks++;
      if (res !== te[i]) $display("FAIL directed_%0d_wd3 op=%0d got %h want %h", i, tf[i], res, te[i]); else n_pass++;
      n_checks++;
      if (lat !== XLEN) $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, XLEN); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] ev [6];
    logic [31:0] a, b, exp, res, res_after;
    logic [4:0] rd, wa;
    logic we, done_after;
    logic [2:0] f;
    int lat, dcyc;
    ev[0] = 32'd0; ev[1] = 32'd1; ev[2] = 32'hFFFF_FFFF;
    ev[3] = 32'h8000_0000; ev[4] = 32'h7FFF_FFFF; ev[5] = 32'd2;
    for (int i = 0; i < 32; i++) begin
      f = 3'(i % 8);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(0, 40); end
        2: begin a = ev[$urandom_range(0, 5)]; b = ev[$urandom_range(0, 5)]; end
        default: begin a = -$urandom_range(1, 5000); b = $urandom_range(0, 1) ? -$urandom_range(1, 50) : $urandom_range(1, 50); end
      endcase
      rd = 5'($urandom_range(0, 31));
      exp = ref_model(f, a, b);
      run_op(f, a, b, rd, res, wa, we, lat, res_after, done_after, dcyc);
      n_checks++;
      if (res !== exp) $display("FAIL random_%0d_wd3 op=%0d a=%h b=%h got %h want %h", i, f, a, b, res, exp); else n_pass++;
      n_checks++;
      if (lat !== XLEN) $display("FAIL random_%0d_latency got %0d want %0d", i, lat, XLEN); else n_pass++;
      n_checks++;
      if (wa !== rd) $display("FAIL random_%0d_wa3 got %0d want %0d", i, wa, rd); else n_pass++;
      n_checks++;
      if (we !== (rd != 5'd0)) $display("FAIL random_%0d_we3 got %b want %b", i, we, (rd != 5'd0)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, ra1, ra2;
    logic [4:0] wa;
    logic we, da1, da2;
    int lat1, lat2, c1, c2;
    run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, r1, wa, we, lat1, ra1, da1, c1);
    run_op(3'b111, 32'd1000, 32'd7, 5'd11, r2, wa, we, lat2, ra2, da2, c2);
    n_checks++;
    if (r1 !== ref_model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0)) $display("FAIL b2b_first_wd3 got %h want %h", r1, ref_model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0)); else n_pass++;
    n_checks++;
    if (r2 !== 32'd6) $display("FAIL b2b_second_wd3 got %h want 6", r2); else n_pass++;
    n_checks++;
    if (c2 - c1 !== XLEN + 2) $display("FAIL b2b_throughput got %0d want %0d cycles", c2 - c1, XLEN + 2); else n_pass++;
    n_checks++;
    if (rf[11] !== 32'd6 || rf[10] !== r1) $display("FAIL b2b_regfile got %h/%h want %h/6", rf[10], rf[11], r1); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int dc0, lat;
    dc0 = done_count;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.a = 32'd1000; bus.b = 32'd7; bus.rd = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd9; bus.b = 32'd9; bus.rd = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 6; k <= XLEN + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== XLEN) $display("FAIL busy_ignore_latency got %0d want %0d", lat, XLEN); else n_pass++;
    n_checks++; if (bus.wd3 !== 32'd142) $display("FAIL busy_ignore_wd3 got %h want 0000008e", bus.wd3); else n_pass++;
    n_checks++; if (bus.wa3 !== 5'd3) $display("FAIL busy_ignore_wa3 got %0d want 3", bus.wa3); else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (done_count !== dc0 + 1) $display("FAIL busy_ignore_done_count got %0d want %0d", done_count - dc0, 1); else n_pass++;
  endtask

  task automatic test_rd_zero();
    logic [31:0] snap [32];
    logic [31:0] res, res_after;
    logic [4:0] wa;
    logic we, done_after, same;
    int lat, dcyc, wc0;
    for (int i = 0; i < 32; i++) snap[i] = rf[i];
    wc0 = wr_count;
    run_op(3'b000, 32'd5, 32'd5, 5'd0, res, wa, we, lat, res_after, done_after, dcyc);
    same = 1'b1;
    for (int i = 0; i < 32; i++) if (rf[i] !== snap[i]) same = 1'b0;
    n_checks++; if (lat !== XLEN) $display("FAIL rd0_done_latency got %0d want %0d", lat, XLEN); else n_pass++;
    n_checks++; if (res !== 32'd25) $display("FAIL rd0_wd3 got %h want 00000019", res); else n_pass++;
    n_checks++; if (we !== 1'b0) $display("FAIL rd0_we3 got %b want 0", we); else n_pass++;
    n_checks++; if (wr_count !== wc0) $display("FAIL rd0_write_count got %0d want %0d", wr_count, wc0); else n_pass++;
    n_checks++; if (rf[0] !== 32'd0) $display("FAIL rd0_x0 got %h want 0", rf[0]); else n_pass++;
    n_checks++; if (same !== 1'b1) $display("FAIL rd0_regfile_unchanged got %b want 1", same); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] res, res_after;
    logic [4:0] wa;
    logic we, done_after;
    int lat, dcyc, dc0, wc0;
    dc0 = done_count;
    wc0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd3; bus.b = 32'd3; bus.rd = 5'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.a = 32'd50; bus.b = 32'd5; bus.rd = 5'd12;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_mid_run got %b want 1", bus.busy); else n_pass++;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_async_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.wd3 !== 32'd0 || bus.wa3 !== 5'd0) $display("FAIL abort_async_outputs got %h/%0d want 0/0", bus.wd3, bus.wa3); else n_pass++;
    n_checks++; if (bus.done !== 1'b0 || bus.we3 !== 1'b0) $display("FAIL abort_async_done_we3 got %b/%b want 0/0", bus.done, bus.we3); else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (done_count !== dc0) $display("FAIL abort_no_done got %0d want %0d", done_count, dc0); else n_pass++;
    n_checks++; if (wr_count !== wc0) $display("FAIL abort_no_write got %0d want %0d", wr_count, wc0); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.wd3 !== 32'd0) $display("FAIL abort_idle_after got %b/%h want 0/0", bus.busy, bus.wd3); else n_pass++;
    run_op(3'b101, 32'd100, 32'd7, 5'd8, res, wa, we, lat, res_after, done_after, dcyc);
    n_checks++; if (res !== 32'd14) $display("FAIL abort_fresh_wd3 got %h want 0000000e", res); else n_pass++;
    n_checks++; if (lat !== XLEN) $display("FAIL abort_fresh_latency got %0d want %0d", lat, XLEN); else n_pass++;
    n_checks++; if (rf[8] !== 32'd14) $display("FAIL abort_fresh_rf8 got %h want 0000000e", rf[8]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_rd_zero();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; iteration count equals XLEN.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  XLEN  operand 1, driven from regfile rd1.
REQ-007 b  input  XLEN  operand 2, driven from regfile rd2.
REQ-008 rd  input  5  destination register index.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 wd3  output  XLEN  result, feeds regfile wd3.
REQ-012 wa3  output  5  latched rd, feeds regfile wa3.
REQ-013 we3  output  1  regfile write enable; equals done AND (wa3 != 0).

Function
REQ-014 FSM states: IDLE, RUN, DONE; IDLE to RUN on start; RUN to DONE after the XLEN-th iteration; DONE to IDLE unconditionally.
REQ-015 On accepting edge: a, b, funct3, rd latched; iteration counter cleared; later operand input changes ignored.
REQ-016 start while busy=1 shall be ignored, with no effect on the in-flight operation.
REQ-017 One radix-2 iteration per RUN cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 Latency fixed: start sampled at edge 0 gives done=1 between edges XLEN and XLEN+1 (32 cycles), for every operand value; no early-out.
REQ-019 Back-to-back: start sampled in the cycle after DONE (state IDLE) shall be accepted; throughput is one op per XLEN+2 cycles.
REQ-020 Signed ops use magnitudes internally; sign fix-up is applied when entering DONE; MULHSU treats a as signed and b as unsigned.
REQ-021 MUL returns product bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN].
REQ-022 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = a.
REQ-023 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
REQ-024 REM result takes the sign of the dividend; DIV truncates toward zero.
REQ-025 wd3 and wa3 hold their last values after DONE until the next completion; done and we3 are high only in DONE.

Reset
REQ-026 reset forces state IDLE, busy=0, done=0, we3=0, wd3=0, wa3=0, counter=0, and clears the operand/accumulator registers, immediately and independent of clk.
REQ-027 Reset asserted mid-RUN shall abort the operation; no write is ever issued for an aborted op.
REQ-028 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package muldiv_pkg holds the funct3 op encodings and the state enum; XLEN defaults to 32 in both the module and the package.
REQ-030 No sub-module: FSM, counter and shared shift datapath sit in muldiv_unit; the outputs connect directly to a regfile write port.

Verification
REQ-031 MUL a=7, b=6, rd=5 -> done and we3 at cycle 32, wd3=0x0000002A, wa3=5.
REQ-032 MULHU a=b=0xFFFFFFFF -> wd3=0xFFFFFFFE; MULH with the same operands -> wd3=0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> wd3=0xFFFFFFFF.
REQ-033 DIVU a=100, b=0 -> wd3=0xFFFFFFFF; REMU -> wd3=100; DIV a=0x80000000, b=0xFFFFFFFF -> wd3=0x80000000; REM -> 0.
REQ-034 DIV a=-7, b=2 -> wd3=0xFFFFFFFD; REM -> wd3=0xFFFFFFFF.
REQ-035 Start MUL 3*3, pulse start again with DIVU at cycle 10, then assert reset at cycle 20 -> second request ignored, no done, outputs zero; a fresh op after reset completes correctly.
REQ-036 MUL 5*5 with rd=0 -> done=1, we3=0; checked against a regfile model: x0 reads 0 and no other register changes.
